// File: rtl/abs_pkg.sv
// Shared types and defaults for the multi-channel ABS controller.
// Per-wheel modulation states plus parameter defaults.
package abs_pkg;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        RELEASE,
        HOLD
    } abs_state_t;

    localparam int DEF_N_WHEELS      = 4;
    localparam int DEF_SPEED_W       = 8;
    localparam int DEF_SLIP_MARGIN   = 10;
    localparam int DEF_MIN_ABS_SPEED = 20;
    localparam int DEF_RELEASE_CYC   = 4;
    localparam int DEF_HOLD_CYC      = 2;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/abs_wheel_channel.sv
// One wheel's release/hold/re-apply FSM with its step timer.
// Valve outputs are registered from the next-state decode.
module abs_wheel_channel
    import abs_pkg::*;
#(
    parameter int RELEASE_CYC = DEF_RELEASE_CYC,
    parameter int HOLD_CYC    = DEF_HOLD_CYC
) (
    input  logic clk,
    input  logic rst,
    input  logic i_demand,
    input  logic i_slip,
    output logic o_brake,
    output logic o_dump,
    output logic o_active
);

    localparam int TMR_W = $clog2(max_int(RELEASE_CYC, HOLD_CYC) + 1);
    localparam logic [TMR_W-1:0] REL_LOAD = TMR_W'(RELEASE_CYC - 1);
    localparam logic [TMR_W-1:0] HLD_LOAD = TMR_W'(HOLD_CYC - 1);

    abs_state_t       r_state;
    abs_state_t       w_next;
    logic [TMR_W-1:0] r_tmr;
    logic [TMR_W-1:0] w_tmr_next;
    logic             w_brake;
    logic             w_dump;
    logic             w_active;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state  <= IDLE;
            r_tmr    <= '0;
            o_brake  <= 1'b0;
            o_dump   <= 1'b0;
            o_active <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_tmr    <= w_tmr_next;
            o_brake  <= w_brake;
            o_dump   <= w_dump;
            o_active <= w_active;
        end
    end

    // Losing demand always wins and clears the timer.
    always_comb begin
        w_next     = r_state;
        w_tmr_next = r_tmr;
        if (!i_demand) begin
            w_next     = IDLE;
            w_tmr_next = '0;
        end else begin
            unique case (r_state)
                IDLE: w_next = APPLY;
                APPLY: begin
                    if (i_slip) begin
                        w_next     = RELEASE;
                        w_tmr_next = REL_LOAD;
                    end
                end
                RELEASE: begin
                    if (r_tmr == '0) begin
                        w_next     = HOLD;
                        w_tmr_next = HLD_LOAD;
                    end else begin
                        w_tmr_next = r_tmr - 1'b1;
                    end
                end
                HOLD: begin
                    if (r_tmr == '0) begin
                        w_next     = i_slip ? RELEASE : APPLY;
                        w_tmr_next = i_slip ? REL_LOAD : '0;
                    end else begin
                        w_tmr_next = r_tmr - 1'b1;
                    end
                end
                default: begin
                    w_next     = IDLE;
                    w_tmr_next = '0;
                end
            endcase
        end
    end

    always_comb begin
        w_brake  = 1'b0;
        w_dump   = 1'b0;
        w_active = 1'b0;
        unique case (w_next)
            APPLY:   w_brake = 1'b1;
            RELEASE: begin
                w_dump   = 1'b1;
                w_active = 1'b1;
            end
            HOLD:    w_active = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: rtl/abs_multi_channel_controller.sv
// Multi-wheel ABS: shared demand and reference speed, slip compare,
// and one independent modulation channel per wheel.
module abs_multi_channel_controller
    import abs_pkg::*;
#(
    parameter int N_WHEELS      = DEF_N_WHEELS,
    parameter int SPEED_W       = DEF_SPEED_W,
    parameter int SLIP_MARGIN   = DEF_SLIP_MARGIN,
    parameter int MIN_ABS_SPEED = DEF_MIN_ABS_SPEED,
    parameter int RELEASE_CYC   = DEF_RELEASE_CYC,
    parameter int HOLD_CYC      = DEF_HOLD_CYC
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        brake_pedal,
    input  logic                        Object_detected,
    input  logic [N_WHEELS*SPEED_W-1:0] wheel_speed,
    output logic [N_WHEELS-1:0]         brake_signal,
    output logic [N_WHEELS-1:0]         dump_valve,
    output logic [N_WHEELS-1:0]         abs_active,
    output logic [SPEED_W-1:0]          ref_speed
);

    localparam logic [SPEED_W:0] MARGIN = (SPEED_W+1)'(SLIP_MARGIN);
    localparam logic [SPEED_W:0] MIN_SP = (SPEED_W+1)'(MIN_ABS_SPEED);

    logic                        w_demand;
    logic [SPEED_W-1:0]          w_max;
    logic [SPEED_W-1:0]          r_ref;
    logic [N_WHEELS*SPEED_W-1:0] r_wheel;
    logic [N_WHEELS-1:0]         w_slip;

    assign w_demand  = brake_pedal | Object_detected;
    assign ref_speed = r_ref;

    always_comb begin
        w_max = '0;
        for (int i = 0; i < N_WHEELS; i++) begin
            if (wheel_speed[i*SPEED_W +: SPEED_W] > w_max)
                w_max = wheel_speed[i*SPEED_W +: SPEED_W];
        end
    end

    // Wheels are registered with the reference so slip compares
    // samples from the same edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ref   <= '0;
            r_wheel <= '0;
        end else begin
            r_ref   <= w_max;
            r_wheel <= wheel_speed;
        end
    end

    for (genvar g = 0; g < N_WHEELS; g++) begin : g_ch
        logic [SPEED_W:0] w_sum;

        assign w_sum = {1'b0, r_wheel[g*SPEED_W +: SPEED_W]} + MARGIN;
        assign w_slip[g] = ({1'b0, r_ref} >= MIN_SP) &&
                           (w_sum < {1'b0, r_ref});

        abs_wheel_channel #(
            .RELEASE_CYC(RELEASE_CYC),
            .HOLD_CYC   (HOLD_CYC)
        ) u_ch (
            .clk     (clk),
            .rst     (rst),
            .i_demand(w_demand),
            .i_slip  (w_slip[g]),
            .o_brake (brake_signal[g]),
            .o_dump  (dump_valve[g]),
            .o_active(abs_active[g])
        );
    end

endmodule

// File: tb/tb_abs_multi_channel_controller.sv
// Scoreboard bench for the multi-wheel ABS controller.
module tb_abs_multi_channel_controller;

    localparam int N = 4;
    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst = 1'b0;
    logic           brake_pedal = 1'b0;
    logic           Object_detected = 1'b0;
    logic [N*W-1:0] wheel_speed = '0;
    logic [N-1:0]   brake_signal;
    logic [N-1:0]   dump_valve;
    logic [N-1:0]   abs_active;
    logic [W-1:0]   ref_speed;

    abs_multi_channel_controller dut (
        .clk            (clk),
        .rst            (rst),
        .brake_pedal    (brake_pedal),
        .Object_detected(Object_detected),
        .wheel_speed    (wheel_speed),
        .brake_signal   (brake_signal),
        .dump_valve     (dump_valve),
        .abs_active     (abs_active),
        .ref_speed      (ref_speed)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [N-1:0] b;
        logic [N-1:0] d;
        logic [N-1:0] a;
        logic [W-1:0] r;
    } exp_t;

    exp_t       q[$];
    int         checks = 0;
    int         errors = 0;
    int         st[N];
    int         cnt[N];
    logic [W-1:0] mref;
    logic [W-1:0] mw[N];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < N; i++) begin
            st[i]  = 0;
            cnt[i] = 0;
            mw[i]  = '0;
        end
        mref = '0;
    endtask

    // States: 0 idle, 1 apply, 2 release, 3 hold; cnt counts up.
    task automatic cyc(input logic p, input logic o,
                       input logic [W-1:0] s0, input logic [W-1:0] s1,
                       input logic [W-1:0] s2, input logic [W-1:0] s3);
        logic [W-1:0] s[N];
        logic         slip[N];
        logic         dmd;
        logic [W-1:0] mx;
        exp_t         e;
        s[0] = s0; s[1] = s1; s[2] = s2; s[3] = s3;
        brake_pedal     = p;
        Object_detected = o;
        wheel_speed     = {s3, s2, s1, s0};
        dmd = p | o;
        for (int i = 0; i < N; i++)
            slip[i] = (int'(mref) >= 20) && (int'(mw[i]) + 10 < int'(mref));
        e = '0;
        for (int i = 0; i < N; i++) begin
            if (!dmd) begin
                st[i] = 0; cnt[i] = 0;
            end else if (st[i] == 0) begin
                st[i] = 1;
            end else if (st[i] == 1) begin
                if (slip[i]) begin st[i] = 2; cnt[i] = 0; end
            end else if (st[i] == 2) begin
                if (cnt[i] == 3) begin st[i] = 3; cnt[i] = 0; end
                else cnt[i]++;
            end else begin
                if (cnt[i] == 1) begin
                    st[i] = slip[i] ? 2 : 1; cnt[i] = 0;
                end else cnt[i]++;
            end
            e.b[i] = (st[i] == 1);
            e.d[i] = (st[i] == 2);
            e.a[i] = (st[i] >= 2);
        end
        mx = '0;
        for (int i = 0; i < N; i++) begin
            if (s[i] > mx) mx = s[i];
            mw[i] = s[i];
        end
        mref = mx;
        e.r  = mx;
        q.push_back(e);
        @(posedge clk);
        #1;
        if (q.size() == 0) begin
            chk("q_empty", 1, 0);
        end else begin
            e = q.pop_front();
            chk("brake", 32'(brake_signal), 32'(e.b));
            chk("dump", 32'(dump_valve), 32'(e.d));
            chk("active", 32'(abs_active), 32'(e.a));
            chk("ref", 32'(ref_speed), 32'(e.r));
            chk("excl", 32'(brake_signal & dump_valve), 0);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_brake"}, 32'(brake_signal), 0);
        chk({tag, "_dump"}, 32'(dump_valve), 0);
        chk({tag, "_active"}, 32'(abs_active), 0);
        chk({tag, "_ref"}, 32'(ref_speed), 0);
    endtask

    initial begin
        model_reset();
        wheel_speed = {4{8'd50}};
        #1;
        chk_zero("reset");
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("reset_held");
        rst = 1'b1;

        for (int k = 0; k < 5; k++) cyc(0, 0, 50, 50, 50, 50);
        for (int k = 0; k < 4; k++) cyc(1, 0, 50, 50, 50, 50);
        for (int k = 0; k < 14; k++) cyc(1, 0, 50, 50, 15, 50);
        for (int k = 0; k < 8; k++) cyc(1, 0, 50, 50, 50, 50);

        for (int k = 0; k < 2; k++) cyc(0, 0, 50, 50, 50, 50);
        for (int k = 0; k < 6; k++) cyc(1, 0, 15, 15, 15, 15);
        for (int k = 0; k < 6; k++) cyc(1, 0, 15, 18, 18, 18);
        for (int k = 0; k < 6; k++) cyc(1, 0, 0, 0, 0, 0);

        for (int k = 0; k < 2; k++) cyc(0, 0, 50, 50, 50, 50);
        for (int k = 0; k < 4; k++) cyc(0, 1, 50, 50, 50, 50);
        for (int k = 0; k < 2; k++) cyc(0, 0, 50, 50, 50, 50);

        for (int k = 0; k < 2; k++) cyc(1, 0, 50, 50, 50, 50);
        for (int k = 0; k < 4; k++) cyc(1, 0, 50, 50, 15, 50);
        chk("mid_release", 32'(st[2]), 2);
        for (int k = 0; k < 2; k++) cyc(0, 0, 50, 50, 15, 50);
        for (int k = 0; k < 4; k++) cyc(1, 0, 50, 50, 15, 50);

        for (int k = 0; k < 20 && st[2] != 3; k++)
            cyc(1, 0, 50, 50, 15, 50);
        chk("mid_hold", 32'(st[2]), 3);
        #3;
        rst = 1'b0;
        #1;
        chk_zero("async");
        model_reset();
        @(posedge clk);
        @(posedge clk);
        #1;
        chk_zero("async_held");
        rst = 1'b1;
        for (int k = 0; k < 4; k++) cyc(1, 0, 50, 50, 50, 50);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
